soma_seg7: RTL and testbench
============================

# soma_seg7

Registered two-operand adder with a seven-segment display driver. It adds two small unsigned operands and presents their sum as one hexadecimal digit pattern on a 7-segment output. It sits at the edge of the design, between switch/operand logic and a single display digit.

## Interface
Parameters:
- `WIDTH`, default 2: operand width in bits. Legal range is 1..3, so the sum always fits one hex digit (at most 14).
- `SEG_ACTIVE_LOW`, default 0: when 1, every segment bit is inverted at the output (common-anode display).

Ports:
- `clk`  input  1: single system clock; all state is on its rising edge.
- `rst_n`  input  1: reset. Asynchronous, active-low.
- `a`  input  WIDTH: operand A, unsigned.
- `b`  input  WIDTH: operand B, unsigned.
- `out`  output  7: segment pattern, bit order {g,f,e,d,c,b,a} (bit 0 = segment a).

## Operation
- Sum width is WIDTH+1 bits, unsigned, with no overflow or wrap. With WIDTH=2 the sum range is 0..6.
- The sum is zero-extended to 4 bits and decoded to an active-high pattern:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- The decoder must be complete for all 16 codes, including codes unreachable at the current WIDTH.
- If SEG_ACTIVE_LOW=1, the registered pattern is bitwise inverted before driving `out`.
- No enable and no handshake: a new sum is captured on every clock.

## Timing
- Asynchronous reset (`rst_n`=0): `out` goes immediately to all segments off. That is 0000000, or 1111111 when SEG_ACTIVE_LOW=1.
- Reset is held off-state for as long as `rst_n` is low, and it overrides any operand change.
- Latency: `a`/`b` are sampled on a rising edge, and `out` shows their sum after that same edge. One cycle, one register stage at the output.
- There is no combinational path from `a`/`b` to `out`, so `out` is glitch-free.
- Operands changing between edges have no effect until the next edge.
- First edge after reset deassertion: `out` reflects the operands present at that edge.
- Deassert `rst_n` synchronously to `clk` externally; the block has no internal reset synchronizer.

## Structure
- Package `soma_pkg` holds:
  - the 16-entry segment constant table (active-high),
  - the segment bit-order constants,
  - a `seg_t` 7-bit typedef.
- Sub-module `seg7_decoder`:
  - purely combinational,
  - 4-bit input, 7-bit active-high output,
  - full case with a default of all segments off.
- Top module `soma_seg7` contains the adder, the zero-extension, the polarity inversion and the output register.

## Test plan
- **Reset.** Hold `rst_n`=0 while toggling `a`/`b` → `out`=0000000 throughout. Release reset with a=0, b=0 → after the next edge `out`=0111111.
- **Exhaustive WIDTH=2 sweep.** Step a=0..3 and b=0..3, one pair per clock.
  - Required `out` one edge later: a=1,b=1→1011011; a=2,b=1→1001111; a=2,b=2→1100110; a=3,b=2→1101101; a=3,b=3→1111101.
  - Every pair must match the decoder table for a+b.
- **Latency.** Change a from 0 to 3 (b=0) mid-cycle → `out` stays 0111111 until the next rising edge, then becomes 1001111.
- **Reset mid-operation.** With a=3, b=3 steady and `out`=1111101, pulse `rst_n` low between edges → `out`=0000000 immediately. After release it returns to 1111101 on the next edge.
- **Polarity and width.**
  - SEG_ACTIVE_LOW=1, a=2, b=2 → `out`=0011001; reset value is 1111111.
  - WIDTH=3, a=7, b=7 → `out`=1111001 ("E").

Source files
------------

// File: rtl/soma_pkg.sv
// Shared types and constants for the soma_seg7 adder/display block.
//   seg_t     : 7-bit segment pattern, bit order {g,f,e,d,c,b,a}
//   Seg*      : bit positions of each segment within seg_t
//   SegOff    : all segments dark (active-high)
//   SegTable  : active-high hex glyphs 0..F indexed by the 4-bit code
package soma_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned SegA = 0;
  localparam int unsigned SegB = 1;
  localparam int unsigned SegC = 2;
  localparam int unsigned SegD = 3;
  localparam int unsigned SegE = 4;
  localparam int unsigned SegF = 5;
  localparam int unsigned SegG = 6;

  localparam seg_t SegOff = 7'b000_0000;

  localparam seg_t SegTable [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,  // 0 1 2 3
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,  // 4 5 6 7
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,  // 8 9 A b
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001   // C d E F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder, active-high output.
//   code : 4-bit hex value to display
//   seg  : segment pattern {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_decoder
  import soma_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);

  always_comb begin
    seg = SegOff;
    case (code)
      4'h0:    seg = SegTable[0];
      4'h1:    seg = SegTable[1];
      4'h2:    seg = SegTable[2];
      4'h3:    seg = SegTable[3];
      4'h4:    seg = SegTable[4];
      4'h5:    seg = SegTable[5];
      4'h6:    seg = SegTable[6];
      4'h7:    seg = SegTable[7];
      4'h8:    seg = SegTable[8];
      4'h9:    seg = SegTable[9];
      4'hA:    seg = SegTable[10];
      4'hB:    seg = SegTable[11];
      4'hC:    seg = SegTable[12];
      4'hD:    seg = SegTable[13];
      4'hE:    seg = SegTable[14];
      4'hF:    seg = SegTable[15];
      default: seg = SegOff;
    endcase
  end

endmodule

// File: rtl/soma_seg7.sv
// Registered two-operand adder driving one seven-segment digit.
// The sum a+b is decoded to a hex glyph and captured every clock; the output
// is taken straight from a register so it never glitches on operand changes.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, forces all segments dark
//   a, b   : unsigned operands, WIDTH bits (1..3 so the sum fits one digit)
//   out    : segment pattern {g,f,e,d,c,b,a}; inverted when SEG_ACTIVE_LOW
module soma_seg7
  import soma_pkg::*;
#(
  parameter int unsigned WIDTH          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [6:0]       out
);

  // XOR mask applied to the active-high glyph; also the "all dark" value.
  localparam seg_t PolMask = SEG_ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;

  logic [WIDTH:0] sum;
  logic [3:0]     code;
  seg_t           seg_hi;
  seg_t           out_d;
  seg_t           out_q;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign code = 4'(sum);

  seg7_decoder u_dec (
    .code (code),
    .seg  (seg_hi)
  );

  // Polarity is folded in ahead of the register so out is a pure flop output.
  assign out_d = seg_hi ^ PolMask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= PolMask;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_soma_seg7.sv
module tb_soma_seg7;

  // Hex glyphs {g,f,e,d,c,b,a}, active-high, written out from the digit shapes.
  localparam logic [6:0] HexSeg [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic       clk;
  logic       rst_n;
  logic [1:0] a, b;
  logic [2:0] a3, b3;
  logic [6:0] out_w2, out_al, out_w3;

  int n_pass  = 0;
  int n_total = 0;

  soma_seg7 #(.WIDTH(2), .SEG_ACTIVE_LOW(1'b0)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out_w2)
  );
  soma_seg7 #(.WIDTH(2), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out_al)
  );
  soma_seg7 #(.WIDTH(3), .SEG_ACTIVE_LOW(1'b0)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .out(out_w3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] model(input int unsigned sum, input bit active_low);
    logic [6:0] p;
    p = HexSeg[sum % 16];
    return active_low ? ~p : p;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] aa, input logic [1:0] bb);
    a  = aa;
    b  = bb;
    a3 = {1'b0, aa};
    b3 = {1'b0, bb};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{a: 2'd1, b: 2'd1, exp: 7'b1011011};
    vecs[1] = '{a: 2'd2, b: 2'd1, exp: 7'b1001111};
    vecs[2] = '{a: 2'd2, b: 2'd2, exp: 7'b1100110};
    vecs[3] = '{a: 2'd3, b: 2'd2, exp: 7'b1101101};
    vecs[4] = '{a: 2'd3, b: 2'd3, exp: 7'b1111101};

    rst_n = 1'b1;
    drive(2'd0, 2'd0);
    #1 rst_n = 1'b0;

    // Reset held while operands toggle.
    for (int i = 0; i < 6; i++) begin
      drive(2'(i), 2'(3 - i));
      #3;
      check("reset_hold_w2", out_w2, 7'b0000000);
      check("reset_hold_al", out_al, 7'b1111111);
      check("reset_hold_w3", out_w3, 7'b0000000);
    end

    // Release with zero operands.
    @(negedge clk);
    drive(2'd0, 2'd0);
    rst_n = 1'b1;
    tick();
    check("first_edge_zero", out_w2, 7'b0111111);

    // Table vectors from the known-answer list.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b);
      tick();
      check("vec_w2", out_w2, vecs[i].exp);
      check("vec_al", out_al, ~vecs[i].exp);
      check("vec_w3", out_w3, vecs[i].exp);
    end

    // Exhaustive WIDTH=2 sweep against the model.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        drive(2'(i), 2'(j));
        tick();
        check("sweep_w2", out_w2, model(i + j, 1'b0));
        check("sweep_al", out_al, model(i + j, 1'b1));
      end
    end

    // Random operands, including the full 3-bit range on the wide instance.
    for (int n = 0; n < 40; n++) begin
      int unsigned ra, rb, wa, wb;
      ra = $urandom_range(3);
      rb = $urandom_range(3);
      wa = $urandom_range(7);
      wb = $urandom_range(7);
      @(negedge clk);
      a  = 2'(ra);
      b  = 2'(rb);
      a3 = 3'(wa);
      b3 = 3'(wb);
      tick();
      check("rand_w2", out_w2, model(ra + rb, 1'b0));
      check("rand_al", out_al, model(ra + rb, 1'b1));
      check("rand_w3", out_w3, model(wa + wb, 1'b0));
    end

    // Latency: a mid-cycle operand change must not show until the next edge.
    @(negedge clk);
    drive(2'd0, 2'd0);
    tick();
    check("lat_before", out_w2, 7'b0111111);
    #2 drive(2'd3, 2'd0);
    #1 check("lat_hold", out_w2, 7'b0111111);
    tick();
    check("lat_after", out_w2, 7'b1001111);

    // Reset pulse between edges with operands steady.
    @(negedge clk);
    drive(2'd3, 2'd3);
    tick();
    check("mid_pre", out_w2, 7'b1111101);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_w2", out_w2, 7'b0000000);
    check("mid_rst_al", out_al, 7'b1111111);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_released_hold", out_w2, 7'b0000000);
    tick();
    check("mid_recover", out_w2, 7'b1111101);

    // Polarity and width corners.
    @(negedge clk);
    drive(2'd2, 2'd2);
    a3 = 3'd7;
    b3 = 3'd7;
    tick();
    check("al_2p2", out_al, 7'b0011001);
    check("w3_7p7", out_w3, 7'b1111001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
